mcu_el2_sram_bank_ctrl: RTL and testbench
=========================================

MCU_EL2_SRAM_BANK_CTRL -- requirements
Module: mcu_el2_sram_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of independent SRAM banks (1..16).
REQ-002 SHALL have parameter ADDR_W, default 12, row address width per bank; depth = 2**ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 32, data bits per bank.
REQ-004 SHALL have parameter ECC_W, default 7, ECC bits per bank.
REQ-005 SHALL have parameter RD_LAT, default 1, cycles from core_clken to core_dout (1..3).
REQ-006 SHALL have parameter INIT_ECC, default 0, ECC value written alongside zero data during init.
REQ-007 SHALL have port clk input 1: the single clock.
REQ-008 SHALL have port rst_l input 1: reset, asynchronous, active-low.
REQ-009 SHALL have port core_clken input NUM_BANKS: per-bank access enable from core.
REQ-010 SHALL have port core_wren input NUM_BANKS: per-bank write enable, qualified by core_clken.
REQ-011 SHALL have port core_addr input NUM_BANKS*ADDR_W: per-bank row address.
REQ-012 SHALL have port core_wr_data input NUM_BANKS*DATA_W and core_wr_ecc input NUM_BANKS*ECC_W: write payload.
REQ-013 SHALL have port core_dout output NUM_BANKS*DATA_W and core_ecc output NUM_BANKS*ECC_W: read return.
REQ-014 SHALL have ports mem_clken, mem_wren (output NUM_BANKS), mem_addr, mem_wr_data, mem_wr_ecc (outputs, matching widths): macro side.
REQ-015 SHALL have ports mem_dout input NUM_BANKS*DATA_W and mem_ecc input NUM_BANKS*ECC_W: macro read data, 1-cycle macro latency.
REQ-016 SHALL have port init_req input 1: pulse to re-zeroize all banks.
REQ-017 SHALL have port init_done output 1: banks initialised, core access allowed.
REQ-018 SHALL have port init_collision output 1: sticky, core access attempted while init_done=0.

Function
REQ-019 FSM states: IDLE, INIT, DRAIN, DONE.
REQ-020 IDLE -> INIT on first clk after rst_l deasserts; INIT row counter starts at 0.
REQ-021 INIT: every cycle all banks driven mem_clken=1, mem_wren=1, mem_addr=counter, data 0, ecc INIT_ECC; counter +1.
REQ-022 INIT -> DRAIN when counter = 2**ADDR_W-1 written; no wrap to 0 is issued.
REQ-023 DRAIN lasts exactly RD_LAT cycles with mem_clken=0, then -> DONE.
REQ-024 DONE: init_done=1; mem_* equals core_* combinationally (zero added request latency).
REQ-025 init_req in DONE -> INIT next cycle, counter cleared, init_done drops same edge; init_req in INIT/DRAIN ignored.
REQ-026 Read path: bank b read data valid on core_dout RD_LAT cycles after core_clken[b]=1, core_wren[b]=0; RD_LAT-1 register stages after mem_dout.
REQ-027 Each pipeline stage per bank loads only when its valid bit is set; otherwise holds last value.
REQ-028 Write with core_clken=1 does not update core_dout.
REQ-029 init_done=0: core_clken ignored, core_dout/core_ecc driven 0; any core_clken bit high sets init_collision.
REQ-030 init_collision clears only on reset or on INIT entry via init_req.
REQ-031 Simultaneous core read in last DONE cycle and init_req: read issued, its data returned even though INIT has begun.

Reset
REQ-032 rst_l low: state IDLE, counter 0, pipeline regs/valids 0, init_done 0, init_collision 0, all mem_* outputs 0.
REQ-033 Reset mid-INIT aborts; init restarts from row 0 after release.

Configuration
REQ-034 Macro MCU_EL2_SRAM_INIT_EN defined: init FSM, init_req, init_collision behaviour as above.
REQ-035 Macro undefined: no FSM or counter; init_done=1 one cycle after reset release; init_req ignored; init_collision tied 0; passthrough and read pipeline unchanged.

Structure
REQ-036 Shared package mcu_el2_pkg SHALL hold the FSM state enum (sram_init_state_e) and RD_LAT limits.
REQ-037 One sub-module mcu_el2_sram_rd_pipe (per-bank RD_LAT-1 stage valid-qualified pipeline), instantiated per bank.

Verification
REQ-038 Reset release, ADDR_W=4 -> 16 INIT cycles writing rows 0..15 with 0/INIT_ECC, RD_LAT DRAIN cycles, then init_done=1.
REQ-039 RD_LAT=3, bank 2 write 0xDEADBEEF row 5, read row 5 -> core_dout bank 2 = 0xDEADBEEF exactly 3 cycles after read clken.
REQ-040 core_clken=0x1 during INIT -> mem_* unaffected, core_dout=0, init_collision=1 and sticky into DONE.
REQ-041 init_req in DONE after writing 0x1234 -> re-init; read returns 0, init_collision cleared.
REQ-042 rst_l low at INIT row 7 -> all outputs 0; after release INIT restarts at row 0.
REQ-043 Built without MCU_EL2_SRAM_INIT_EN -> init_done=1 one cycle after reset; init_req pulse produces no mem writes.

Source files
------------

// File: rtl/mcu_el2_pkg.sv
// Shared definitions for the EL2 SRAM bank controller: init FSM encoding and read-latency limits.
package mcu_el2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DRAIN,
    DONE
  } sram_init_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Keeps an out-of-range RD_LAT from building a negative-depth pipe.
  function automatic int clamp_rd_lat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mcu_el2_sram_rd_pipe.sv
// Per-bank read return pipe: RD_LAT-1 valid-qualified stages behind the 1-cycle macro output.
module mcu_el2_sram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int ECC_W  = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [ECC_W-1:0]  mem_ecc,
  output logic [DATA_W-1:0] dout,
  output logic [ECC_W-1:0]  ecc,
  output logic              dout_vld
);

  localparam int STAGES = RD_LAT - 1;

  // High in the cycle mem_dout carries data for a read issued one cycle earlier.
  logic mem_vld;

  always_ff @(posedge clk or negedge rst_l) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (!rst_l) mem_vld <= 1'b0;
    else        mem_vld <= rd_issue;
  end

  if (STAGES == 0) begin : g_bypass
    assign dout     = mem_dout;
    assign ecc      = mem_ecc;
    assign dout_vld = mem_vld;
  end else begin : g_stages
    logic [STAGES-1:0]             vld;
    logic [STAGES-1:0][DATA_W-1:0] data_q;
    logic [STAGES-1:0][ECC_W-1:0]  ecc_q;

    always_ff @(posedge clk or negedge rst_l) begin
      // NOTE: these few stage flops must read 0 out of reset, so they are reset; the SRAM array never is.
      if (!rst_l) begin
        vld    <= '0;
        data_q <= '0;
        ecc_q  <= '0;
      end else begin
        vld[0] <= mem_vld;
        if (mem_vld) begin
          data_q[0] <= mem_dout;
          ecc_q[0]  <= mem_ecc;
        end
        for (int i = 1; i < STAGES; i++) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            data_q[i] <= data_q[i-1];
            ecc_q[i]  <= ecc_q[i-1];
          end
        end
      end
    end

    assign dout     = data_q[STAGES-1];
    assign ecc      = ecc_q[STAGES-1];
    assign dout_vld = vld[STAGES-1];
  end

endmodule

// File: rtl/mcu_el2_sram_bank_ctrl.sv
// Banked SRAM front end: zeroization engine, core/macro port mux and per-bank read return pipes.
// The init FSM exists only when MCU_EL2_SRAM_INIT_EN is defined; otherwise banks open one cycle after reset.
module mcu_el2_sram_bank_ctrl
  import mcu_el2_pkg::*;
#(
  parameter int               NUM_BANKS = 4,
  parameter int               ADDR_W    = 12,
  parameter int               DATA_W    = 32,
  parameter int               ECC_W     = 7,
  parameter int               RD_LAT    = 1,
  parameter logic [ECC_W-1:0] INIT_ECC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic [NUM_BANKS-1:0]           core_clken,
  input  logic [NUM_BANKS-1:0]           core_wren,
  input  logic [NUM_BANKS*ADDR_W-1:0]    core_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]    core_wr_data,
  input  logic [NUM_BANKS*ECC_W-1:0]     core_wr_ecc,
  output logic [NUM_BANKS*DATA_W-1:0]    core_dout,
  output logic [NUM_BANKS*ECC_W-1:0]     core_ecc,
  output logic [NUM_BANKS-1:0]           mem_clken,
  output logic [NUM_BANKS-1:0]           mem_wren,
  output logic [NUM_BANKS*ADDR_W-1:0]    mem_addr,
  output logic [NUM_BANKS*DATA_W-1:0]    mem_wr_data,
  output logic [NUM_BANKS*ECC_W-1:0]     mem_wr_ecc,
  input  logic [NUM_BANKS*DATA_W-1:0]    mem_dout,
  input  logic [NUM_BANKS*ECC_W-1:0]     mem_ecc,
  input  logic                           init_req,
  output logic                           init_done,
  output logic                           init_collision
);

  localparam int LAT = clamp_rd_lat(RD_LAT);

  logic              init_active;
  logic [ADDR_W-1:0] init_row;

`ifdef MCU_EL2_SRAM_INIT_EN
  sram_init_state_e state;
  logic [1:0]       drain_cnt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state          <= IDLE;
      init_row       <= '0;
      drain_cnt      <= '0;
      init_done      <= 1'b0;
      init_collision <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= INIT;
          init_row <= '0;
        end
        INIT: begin
          // Last row is written this cycle; the counter parks instead of wrapping.
          if (init_row == '1) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            init_row <= init_row + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'(LAT - 1)) begin
            state     <= DONE;
            init_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          if (init_req) begin
            state     <= INIT;
            init_row  <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // Sticky through DONE; only a requested re-init wipes it.
      if (state == DONE && init_req)        init_collision <= 1'b0;
      else if (!init_done && (|core_clken)) init_collision <= 1'b1;
    end
  end

  assign init_active = (state == INIT);
`else
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  assign init_active    = 1'b0;
  assign init_row       = '0;
  assign init_collision = 1'b0;

  logic unused_init_req;
  assign unused_init_req = init_req;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    mem_clken   = '0;
    mem_wren    = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ecc  = '0;
    if (init_done) begin
      mem_clken   = core_clken;
      mem_wren    = core_wren;
      mem_addr    = core_addr;
      mem_wr_data = core_wr_data;
      mem_wr_ecc  = core_wr_ecc;
    end else if (init_active) begin
      mem_clken  = '1;
      mem_wren   = '1;
      mem_addr   = {NUM_BANKS{init_row}};
      mem_wr_ecc = {NUM_BANKS{INIT_ECC}};
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] pipe_dout;
    logic [ECC_W-1:0]  pipe_ecc;
    logic              pipe_vld;

    mcu_el2_sram_rd_pipe #(
      .DATA_W (DATA_W),
      .ECC_W  (ECC_W),
      .RD_LAT (LAT)
    ) u_rd_pipe (
      .clk      (clk),
      .rst_l    (rst_l),
      .rd_issue (init_done & core_clken[b] & ~core_wren[b]),
      .mem_dout (mem_dout[b*DATA_W +: DATA_W]),
      .mem_ecc  (mem_ecc[b*ECC_W +: ECC_W]),
      .dout     (pipe_dout),
      .ecc      (pipe_ecc),
      .dout_vld (pipe_vld)
    );

    // A read issued in the last DONE cycle still returns while a re-init is running.
    assign core_dout[b*DATA_W +: DATA_W] = (init_done || pipe_vld) ? pipe_dout : '0;
    assign core_ecc[b*ECC_W +: ECC_W]    = (init_done || pipe_vld) ? pipe_ecc  : '0;
  end

endmodule

// File: tb/tb_mcu_el2_sram_bank_ctrl.sv
// Self-checking bench for mcu_el2_sram_bank_ctrl: SRAM macro model plus a shadow-memory reference.
// Runs the init-engine scenarios when MCU_EL2_SRAM_INIT_EN is defined, the bypass scenarios otherwise.
module tb_mcu_el2_sram_bank_ctrl;

  localparam int NB    = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int EW    = 7;
  localparam int LAT   = 3;
  localparam int DEPTH = 1 << AW;
  localparam logic [EW-1:0] IECC = 7'h2B;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic [NB-1:0]    core_clken = '0;
  logic [NB-1:0]    core_wren = '0;
  logic [NB*AW-1:0] core_addr = '0;
  logic [NB*DW-1:0] core_wr_data = '0;
  logic [NB*EW-1:0] core_wr_ecc = '0;
  logic [NB*DW-1:0] core_dout;
  logic [NB*EW-1:0] core_ecc;
  logic [NB-1:0]    mem_clken;
  logic [NB-1:0]    mem_wren;
  logic [NB*AW-1:0] mem_addr;
  logic [NB*DW-1:0] mem_wr_data;
  logic [NB*EW-1:0] mem_wr_ecc;
  logic [NB*DW-1:0] mem_dout;
  logic [NB*EW-1:0] mem_ecc;
  logic             init_req = 1'b0;
  logic             init_done;
  logic             init_collision;

  mcu_el2_sram_bank_ctrl #(
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ECC_W     (EW),
    .RD_LAT    (LAT),
    .INIT_ECC  (IECC)
  ) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .core_clken     (core_clken),
    .core_wren      (core_wren),
    .core_addr      (core_addr),
    .core_wr_data   (core_wr_data),
    .core_wr_ecc    (core_wr_ecc),
    .core_dout      (core_dout),
    .core_ecc       (core_ecc),
    .mem_clken      (mem_clken),
    .mem_wren       (mem_wren),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_wr_ecc     (mem_wr_ecc),
    .mem_dout       (mem_dout),
    .mem_ecc        (mem_ecc),
    .init_req       (init_req),
    .init_done      (init_done),
    .init_collision (init_collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat_d(input int b, input int r);
    return 32'hA500_0000 | 32'(b << 8) | 32'(r);
  endfunction

  function automatic logic [EW-1:0] pat_e(input int b, input int r);
    return 7'(b * 16 + r);
  endfunction

  // SRAM macro model: 1-cycle read latency, output holds between reads.
  logic [DW-1:0] arr_d [NB][DEPTH];
  logic [EW-1:0] arr_e [NB][DEPTH];
  logic [DW-1:0] mac_d [NB];
  logic [EW-1:0] mac_e [NB];
  bit            seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int b = 0; b < NB; b++) begin
        for (int r = 0; r < DEPTH; r++) begin
          arr_d[b][r] <= pat_d(b, r);
          arr_e[b][r] <= pat_e(b, r);
        end
        mac_d[b] <= '0;
        mac_e[b] <= '0;
      end
      seeded <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (mem_clken[b]) begin
          if (mem_wren[b]) begin
            arr_d[b][mem_addr[b*AW +: AW]] <= mem_wr_data[b*DW +: DW];
            arr_e[b][mem_addr[b*AW +: AW]] <= mem_wr_ecc[b*EW +: EW];
          end else begin
            mac_d[b] <= arr_d[b][mem_addr[b*AW +: AW]];
            mac_e[b] <= arr_e[b][mem_addr[b*AW +: AW]];
          end
        end
      end
    end
  end

  always_comb begin
    mem_dout = '0;
    mem_ecc  = '0;
    for (int b = 0; b < NB; b++) begin
      mem_dout[b*DW +: DW] = mac_d[b];
      mem_ecc[b*EW +: EW]  = mac_e[b];
    end
  end

  // Reference: shadow contents, reads in flight, last returned value per bank.
  typedef struct {
    int            due;
    int            bank;
    logic [DW-1:0] d;
    logic [EW-1:0] e;
  } rd_exp_t;

  logic [DW-1:0] exp_d [NB][DEPTH];
  logic [EW-1:0] exp_e [NB][DEPTH];
  logic [DW-1:0] last_d [NB];
  logic [EW-1:0] last_e [NB];
  rd_exp_t       rd_q [$];
  bit            exp_coll = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_inputs();
    core_clken   = '0;
    core_wren    = '0;
    core_addr    = '0;
    core_wr_data = '0;
    core_wr_ecc  = '0;
    init_req     = 1'b0;
  endtask

  task automatic set_access(input int b, input bit wr, input int row,
                            input logic [DW-1:0] d, input logic [EW-1:0] e);
    clear_inputs();
    core_clken[b]            = 1'b1;
    core_wren[b]             = wr;
    core_addr[b*AW +: AW]    = AW'(row);
    core_wr_data[b*DW +: DW] = d;
    core_wr_ecc[b*EW +: EW]  = e;
  endtask

  task automatic check_outputs(input bit done_exp);
    for (int b = 0; b < NB; b++) begin
      bit due = 1'b0;
      for (int i = 0; i < rd_q.size(); i++) begin
        if (rd_q[i].due == cyc && rd_q[i].bank == b) begin
          due       = 1'b1;
          last_d[b] = rd_q[i].d;
          last_e[b] = rd_q[i].e;
        end
      end
      check($sformatf("core_dout[%0d]", b), 64'(core_dout[b*DW +: DW]),
            (due || done_exp) ? 64'(last_d[b]) : 64'(0));
      check($sformatf("core_ecc[%0d]", b), 64'(core_ecc[b*EW +: EW]),
            (due || done_exp) ? 64'(last_e[b]) : 64'(0));
    end
    for (int i = rd_q.size() - 1; i >= 0; i--)
      if (rd_q[i].due <= cyc) rd_q.delete(i);
    check("init_done", 64'(init_done), 64'(done_exp));
    check("init_collision", 64'(init_collision), 64'(exp_coll));
  endtask

  task automatic check_reset();
    check("rst_mem_clken", 64'(mem_clken), 64'(0));
    check("rst_mem_wren", 64'(mem_wren), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wr_ecc", 64'(mem_wr_ecc), 64'(0));
    check("rst_core_ecc", 64'(core_ecc), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_init_collision", 64'(init_collision), 64'(0));
    for (int b = 0; b < NB; b++) begin
      check($sformatf("rst_mem_wr_data[%0d]", b), 64'(mem_wr_data[b*DW +: DW]), 64'(0));
      check($sformatf("rst_core_dout[%0d]", b), 64'(core_dout[b*DW +: DW]), 64'(0));
    end
  endtask

  // One cycle of core traffic in DONE: update the shadow, check passthrough and returns.
  task automatic done_cycle();
    for (int b = 0; b < NB; b++) begin
      if (core_clken[b]) begin
        int a = int'(core_addr[b*AW +: AW]);
        if (core_wren[b]) begin
          exp_d[b][a] = core_wr_data[b*DW +: DW];
          exp_e[b][a] = core_wr_ecc[b*EW +: EW];
        end else begin
          rd_exp_t x;
          x.due  = cyc + LAT;
          x.bank = b;
          x.d    = exp_d[b][a];
          x.e    = exp_e[b][a];
          rd_q.push_back(x);
        end
      end
    end
    @(negedge clk);
    check("pass_clken", 64'(mem_clken), 64'(core_clken));
    check("pass_wren", 64'(mem_wren), 64'(core_wren));
    check("pass_addr", 64'(mem_addr), 64'(core_addr));
    check("pass_wr_ecc", 64'(mem_wr_ecc), 64'(core_wr_ecc));
    for (int b = 0; b < NB; b++)
      check($sformatf("pass_wr_data[%0d]", b), 64'(mem_wr_data[b*DW +: DW]),
            64'(core_wr_data[b*DW +: DW]));
    check_outputs(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) done_cycle();
  endtask

  task automatic rand_traffic(input int n);
    repeat (n) begin
      core_clken   = 4'($urandom);
      core_wren    = 4'($urandom);
      core_addr    = 16'($urandom);
      core_wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      core_wr_ecc  = 28'($urandom);
      init_req     = 1'b0;
      done_cycle();
    end
    clear_inputs();
  endtask

  // Releases reset just after an edge and walks the pre-enable cycle; returns #1 after the next edge.
  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    rd_q.delete();
    for (int b = 0; b < NB; b++) begin
      last_d[b] = '0;
      last_e[b] = '0;
    end
    exp_coll = 1'b0;
`ifndef MCU_EL2_SRAM_INIT_EN
    core_clken = 4'hF;
`endif
    @(negedge clk);
    check("pre_mem_clken", 64'(mem_clken), 64'(0));
    check("pre_mem_wren", 64'(mem_wren), 64'(0));
    check_outputs(1'b0);
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // Called #1 after the edge that entered INIT.
  task automatic init_sequence(input int collide_row, input int abort_row);
    clear_inputs();
    exp_coll = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < DEPTH; r++) begin
        exp_d[b][r] = '0;
        exp_e[b][r] = IECC;
      end
    end
    for (int r = 0; r < DEPTH; r++) begin
      if (r == collide_row) begin
        core_clken = 4'h1;
        core_addr  = 16'hFFFF;
      end
      if (r == 4) init_req = 1'b1;
      @(negedge clk);
      check("init_clken", 64'(mem_clken), 64'(4'hF));
      check("init_wren", 64'(mem_wren), 64'(4'hF));
      check("init_wr_ecc", 64'(mem_wr_ecc), 64'({NB{IECC}}));
      for (int b = 0; b < NB; b++) begin
        check($sformatf("init_addr[%0d]", b), 64'(mem_addr[b*AW +: AW]), 64'(r));
        check($sformatf("init_wr_data[%0d]", b), 64'(mem_wr_data[b*DW +: DW]), 64'(0));
      end
      check_outputs(1'b0);
      if (r == abort_row) begin
        rst_l = 1'b0;
        #1;
        clear_inputs();
        check_reset();
        return;
      end
      @(posedge clk);
      #1;
      init_req = 1'b0;
      if (r == collide_row) begin
        clear_inputs();
        exp_coll = 1'b1;
      end
    end
    for (int d = 0; d < LAT; d++) begin
      @(negedge clk);
      check("drain_clken", 64'(mem_clken), 64'(0));
      check("drain_wren", 64'(mem_wren), 64'(0));
      check_outputs(1'b0);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      for (int r = 0; r < DEPTH; r++) begin
        exp_d[b][r] = pat_d(b, r);
        exp_e[b][r] = pat_e(b, r);
      end
      last_d[b] = '0;
      last_e[b] = '0;
    end
    clear_inputs();
    rst_l = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset();

`ifdef MCU_EL2_SRAM_INIT_EN
    release_reset();
    init_sequence(-1, 7);
    release_reset();
    init_sequence(3, -1);

    set_access(2, 1'b1, 5, 32'hDEAD_BEEF, 7'h11);
    done_cycle();
    set_access(2, 1'b0, 5, '0, '0);
    done_cycle();
    idle(4);

    rand_traffic(150);

    set_access(0, 1'b1, 3, 32'h0000_1234, 7'h0C);
    done_cycle();
    set_access(0, 1'b0, 3, '0, '0);
    init_req = 1'b1;
    done_cycle();
    init_sequence(-1, -1);
    set_access(0, 1'b0, 3, '0, '0);
    done_cycle();
    idle(4);

    rand_traffic(100);
`else
    release_reset();
    set_access(0, 1'b1, 3, 32'h0000_1234, 7'h0C);
    done_cycle();
    clear_inputs();
    init_req = 1'b1;
    done_cycle();
    idle(2);
    set_access(0, 1'b0, 3, '0, '0);
    done_cycle();
    idle(4);

    set_access(2, 1'b1, 5, 32'hDEAD_BEEF, 7'h11);
    done_cycle();
    set_access(2, 1'b0, 5, '0, '0);
    done_cycle();
    idle(4);

    rand_traffic(250);
`endif

    idle(LAT + 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests_run %0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
